// File: rtl/demux_1x4_dispatcher_pkg.sv
// Shared definitions for the 1:4 demux dispatcher.
//   state_e      : dispatcher FSM state (holding register empty / full)
//   ModeRr/Dir   : values of the mode input (round-robin / directed)
//   NumCh        : number of output channels
//   next_ch()    : channel index plus one, wrapping 3 -> 0
package demux_1x4_dispatcher_pkg;

  localparam int unsigned NumCh = 4;
  localparam int unsigned ChW   = 2;

  localparam logic ModeRr  = 1'b0;
  localparam logic ModeDir = 1'b1;

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  function automatic logic [ChW-1:0] next_ch(input logic [ChW-1:0] ch);
    return ch + 2'd1;
  endfunction

endpackage

// File: rtl/demux_1x4_dispatcher_if.sv
// Producer/consumer bus of the 1:4 demux dispatcher.
//   mode, in_valid, in_data, in_dest, in_ready : producer side (single source)
//   out_valid, out_ready, out_data             : four consumers on one data bus
//   S1, S0                                     : demux select (current target)
//   busy, xfer_count                           : status
// Modport master is the dispatcher; slave is the surrounding environment.
interface demux_1x4_dispatcher_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 16
) ();

  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_dest;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data;
  logic             S1;
  logic             S0;
  logic             busy;
  logic [CNTW-1:0]  xfer_count;

  modport master (
    input  mode, in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data, S1, S0, busy, xfer_count
  );

  modport slave (
    output mode, in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data, S1, S0, busy, xfer_count
  );

endinterface

// File: rtl/demux_1x4_dispatcher_demux.sv
// Plain 1:4 demultiplexer: routes in_i to output {s1_i,s0_i}; all others 0.
//   in_i        : signal to steer
//   s1_i, s0_i  : select
//   y0_o..y3_o  : outputs
module demux_1x4_dispatcher_demux (
  input  logic in_i,
  input  logic s0_i,
  input  logic s1_i,
  output logic y0_o,
  output logic y1_o,
  output logic y2_o,
  output logic y3_o
);

  assign y0_o = in_i & ~s1_i & ~s0_i;
  assign y1_o = in_i & ~s1_i &  s0_i;
  assign y2_o = in_i &  s1_i & ~s0_i;
  assign y3_o = in_i &  s1_i &  s0_i;

endmodule

// File: rtl/demux_1x4_dispatcher.sv
// Sequencer for a 1:4 demux datapath. Takes one word at a time from a
// valid/ready producer into a holding register and offers it to exactly one of
// four consumers, chosen round-robin or by in_dest (directed).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : producer/consumer/status signals (master modport)
// In round-robin mode a word stalled for TIMEOUT cycles is moved to the next
// channel; directed words wait on their channel indefinitely.
module demux_1x4_dispatcher
  import demux_1x4_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNTW    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_1x4_dispatcher_if.master  bus
);

  // Counter only needs to hold 0..TIMEOUT-1; the skip fires on the cycle that
  // would have reached TIMEOUT.
  localparam int unsigned StallW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [StallW-1:0] StallLast = StallW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [ChW-1:0]   target_q, target_d;
  logic             mode_q, mode_d;
  logic [ChW-1:0]   rr_q, rr_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic [CNTW-1:0]  xfer_q, xfer_d;

  logic             in_ready;
  logic             fire;
  logic             accept;
  logic [NumCh-1:0] out_valid;

  assign fire   = bus.out_ready[target_q];
  assign accept = bus.in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    target_d = target_q;
    mode_d   = mode_q;
    rr_d     = rr_q;
    stall_d  = stall_q;
    xfer_d   = xfer_q;
    in_ready = 1'b0;

    unique case (state_q)
      StEmpty: begin
        in_ready = 1'b1;
      end
      StFull: begin
        // Ready passes straight through so a full stream moves one word per clock.
        in_ready = fire;
        if (fire) begin
          xfer_d  = xfer_q + CNTW'(1);
          stall_d = '0;
          if (mode_q == ModeRr) begin
            rr_d = next_ch(target_q);
          end
          if (!bus.in_valid) begin
            state_d = StEmpty;
          end
        end else if ((TIMEOUT != 0) && (mode_q == ModeRr)) begin
          if (stall_q == StallLast) begin
            target_d = next_ch(target_q);
            rr_d     = next_ch(next_ch(target_q));
            stall_d  = '0;
          end else begin
            stall_d = stall_q + StallW'(1);
          end
        end
      end
      default: ;
    endcase

    // A new word picks its target from the pointer as already advanced by a
    // same-cycle transfer, so back-to-back RR words walk the channels.
    if (accept) begin
      data_d   = bus.in_data;
      mode_d   = bus.mode;
      target_d = (bus.mode == ModeDir) ? bus.in_dest : rr_d;
      state_d  = StFull;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      data_q   <= '0;
      target_q <= '0;
      mode_q   <= ModeRr;
      rr_q     <= '0;
      stall_q  <= '0;
      xfer_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      rr_q     <= rr_d;
      stall_q  <= stall_d;
      xfer_q   <= xfer_d;
    end
  end

  demux_1x4_dispatcher_demux u_demux (
    .in_i (state_q == StFull),
    .s0_i (target_q[0]),
    .s1_i (target_q[1]),
    .y0_o (out_valid[0]),
    .y1_o (out_valid[1]),
    .y2_o (out_valid[2]),
    .y3_o (out_valid[3])
  );

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = data_q;
  assign bus.S1         = target_q[1];
  assign bus.S0         = target_q[0];
  assign bus.busy       = (state_q == StFull);
  assign bus.xfer_count = xfer_q;

endmodule

// File: tb/tb_demux_1x4_dispatcher.sv
// Self-checking bench for demux_1x4_dispatcher: directed scenarios followed by
// randomized traffic, all compared each cycle against a behavioural model of
// the holding register, round-robin pointer and skip rule, plus an in-order
// scoreboard of accepted words.
module tb_demux_1x4_dispatcher;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNTW    = 4;

  logic clk = 1'b0;
  logic rst_n;

  demux_1x4_dispatcher_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  demux_1x4_dispatcher #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT),
    .CNTW    (CNTW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  bit         m_full;
  logic [7:0] m_data;
  int         m_tgt, m_rr, m_stall, m_cnt, m_mode;
  logic [7:0] sb_q[$];
  int         ch_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_data = '0; m_tgt = 0; m_rr = 0; m_stall = 0; m_cnt = 0; m_mode = 0;
    sb_q.delete();
    ch_log.delete();
  endtask

  task automatic model_load();
    m_data = bus.in_data;
    m_mode = int'(bus.mode);
    m_tgt  = bus.mode ? int'(bus.in_dest) : m_rr;
    m_full = 1'b1;
    sb_q.push_back(bus.in_data);
  endtask

  task automatic check_outputs();
    logic [3:0] exp_ov;
    exp_ov = m_full ? 4'(1 << m_tgt) : 4'b0;
    check_eq("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check_eq("onehot", 32'($countones(bus.out_valid) <= 1), 32'd1);
    check_eq("in_ready", 32'(bus.in_ready), 32'(!m_full || bus.out_ready[m_tgt]));
    check_eq("out_data", 32'(bus.out_data), 32'(m_data));
    check_eq("sel", 32'({bus.S1, bus.S0}), 32'(m_tgt));
    check_eq("busy", 32'(bus.busy), 32'(m_full));
    check_eq("xfer_count", 32'(bus.xfer_count), 32'(m_cnt));
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int ch;
    if (!m_full) begin
      if (bus.in_valid) model_load();
    end else if (bus.out_ready[m_tgt]) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check_eq("sb_data", 32'(bus.out_data), 32'(sb_q.pop_front()));
      ch = 4;
      for (int i = 0; i < 4; i++) if (bus.out_valid[i]) ch = i;
      ch_log.push_back(ch);
      m_cnt   = (m_cnt + 1) % (1 << CNTW);
      m_stall = 0;
      if (m_mode == 0) m_rr = (m_tgt + 1) % 4;
      if (bus.in_valid) model_load();
      else m_full = 1'b0;
    end else if (m_mode == 0) begin
      m_stall++;
      if (m_stall == TIMEOUT) begin
        m_tgt   = (m_tgt + 1) % 4;
        m_rr    = (m_tgt + 1) % 4;
        m_stall = 0;
      end
    end
  endtask

  // Called one time unit after a rising edge with this cycle's inputs applied.
  task automatic cycle();
    #4;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges while a word is held.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_xfer", 32'(bus.xfer_count), 32'd0);
    model_reset();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ch[5];
    int n_hold;
    int base;

    bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dest = '0;
    bus.out_ready = '0;
    sync_reset();
    check_eq("reset_xfer", 32'(bus.xfer_count), 32'd0);
    check_eq("reset_out_data", 32'(bus.out_data), 32'd0);
    cycle();

    // 1: round-robin streaming, every consumer ready.
    bus.mode = 1'b0; bus.out_ready = 4'hf; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 8'(8'h11 * (i + 1));
      cycle();
    end
    bus.in_valid = 1'b0;
    repeat (2) cycle();
    exp_ch = '{0, 1, 2, 3, 0};
    check_eq("s1_nxfer", 32'(ch_log.size()), 32'd5);
    if (ch_log.size() == 5) foreach (exp_ch[i]) check_eq("s1_ch", 32'(ch_log[i]), 32'(exp_ch[i]));
    check_eq("s1_count", 32'(bus.xfer_count), 32'd5);

    // 2: directed word to ch2 stalled for 40 clocks.
    bus.mode = 1'b1; bus.in_dest = 2'd2; bus.in_data = 8'hA5; bus.out_ready = 4'b0000;
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    n_hold = 0;
    repeat (40) begin
      if (bus.out_valid == 4'b0100 && {bus.S1, bus.S0} == 2'b10 && !bus.in_ready) n_hold++;
      cycle();
    end
    check_eq("s2_hold", 32'(n_hold), 32'd40);
    bus.out_ready = 4'b0100;
    cycle();
    bus.out_ready = 4'b0000;
    cycle();
    check_eq("s2_count", 32'(bus.xfer_count), 32'd6);
    check_eq("s2_ch", 32'(ch_log[ch_log.size() - 1]), 32'd2);

    // 3: RR word stuck on ch0 skips to ch1 after TIMEOUT stalls.
    sync_reset();
    bus.mode = 1'b0; bus.out_ready = 4'b1110; bus.in_data = 8'h5A; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    n_hold = 0;
    repeat (20) begin
      if (bus.out_valid == 4'b0001) n_hold++;
      cycle();
    end
    check_eq("s3_stall", 32'(n_hold), 32'(TIMEOUT));
    bus.in_data = 8'h5B; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (2) cycle();
    check_eq("s3_nxfer", 32'(ch_log.size()), 32'd2);
    if (ch_log.size() == 2) begin
      check_eq("s3_ch_a", 32'(ch_log[0]), 32'd1);
      check_eq("s3_ch_b", 32'(ch_log[1]), 32'd2);
    end

    // 4: asynchronous reset while 0x77 is stalled.
    bus.out_ready = 4'b0000; bus.in_data = 8'h77; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (5) cycle();
    async_reset();
    bus.out_ready = 4'hf;
    repeat (3) cycle();
    check_eq("s4_count", 32'(bus.xfer_count), 32'd0);
    check_eq("s4_nxfer", 32'(ch_log.size()), 32'd0);
    bus.in_data = 8'h88; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    check_eq("s4_ch", 32'(ch_log.size() == 1 ? ch_log[0] : 9), 32'd0);

    // 5: transfer counter wrap with a 4-bit counter.
    sync_reset();
    bus.mode = 1'b0; bus.out_ready = 4'hf; bus.in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 8'(i);
      cycle();
      if (i == 15) check_eq("s5_cnt_f", 32'(bus.xfer_count), 32'hf);
      if (i == 16) check_eq("s5_cnt_0", 32'(bus.xfer_count), 32'h0);
    end
    bus.in_valid = 1'b0;
    cycle();
    check_eq("s5_cnt_1", 32'(bus.xfer_count), 32'h1);

    // 6: mode flips to directed while an RR word for ch1 is held.
    base = ch_log.size();
    bus.out_ready = 4'b0000; bus.in_data = 8'h66; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0; bus.mode = 1'b1; bus.in_dest = 2'd3;
    repeat (3) cycle();
    bus.out_ready = 4'b0010; bus.in_data = 8'h67; bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0; bus.out_ready = 4'b1000;
    repeat (2) cycle();
    check_eq("s6_nxfer", 32'(ch_log.size() - base), 32'd2);
    if (ch_log.size() - base == 2) begin
      check_eq("s6_ch_held", 32'(ch_log[base]), 32'd1);
      check_eq("s6_ch_next", 32'(ch_log[base + 1]), 32'd3);
    end

    // Randomized traffic: mixed readiness, mostly stalled, then fully open.
    sync_reset();
    for (int i = 0; i < 1500; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.mode     = 1'($urandom_range(0, 1));
      bus.in_dest  = 2'($urandom_range(0, 3));
      bus.in_data  = 8'($urandom);
      if (i < 500) bus.out_ready = 4'($urandom);
      else if (i < 1000) bus.out_ready = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      else bus.out_ready = 4'hf;
      cycle();
    end
    bus.in_valid = 1'b0; bus.out_ready = 4'hf;
    repeat (3) cycle();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
